// File: rtl/ysyx_23060059_axi_pkg.sv
// AXI-lite definitions shared by the read arbiter and its future write/xbar siblings.
package ysyx_23060059_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ERR,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/axi_lite_rd_rr_arbiter_if.sv
// Bus bundle around the read arbiter: upstream master AR/R channels, downstream port and grant visibility.
interface axi_lite_rd_rr_arbiter_if #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [N_MST*ADDR_W-1:0] s_araddr;
  logic [N_MST-1:0]        s_arvalid;
  logic [N_MST-1:0]        s_arready;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic [N_MST-1:0]        s_rvalid;
  logic [N_MST-1:0]        s_rready;
  logic [ADDR_W-1:0]       m_araddr;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [N_MST-1:0]        grant;

  // Arbiter side.
  modport slave (
    input  s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready, grant
  );

  // Environment side: upstream masters plus downstream memory.
  modport master (
    output s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready, grant
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin from ptr_i (wrapping) or lowest-index-first, one-hot result.
module rr_pick #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             rr_mode_i,
  output logic [N-1:0]     gnt_o
);

  logic [N-1:0] at_or_after;
  logic [N-1:0] masked;
  logic [N-1:0] base;

  // Requests at/after the pointer take precedence; otherwise wrap to the full set.
  assign at_or_after = ~((N'(1) << ptr_i) - N'(1));
  assign masked      = req_i & at_or_after;
  assign base        = (rr_mode_i && (|masked)) ? masked : req_i;
  assign gnt_o       = base & (~base + N'(1));

endmodule

// File: rtl/axi_lite_rd_rr_arbiter.sv
// N-master AXI-lite read arbiter: one transaction in flight, fixed or round-robin priority,
// watchdog converts a silent downstream slave into SLVERR and drains the late beat.
module axi_lite_rd_rr_arbiter
  import ysyx_23060059_axi_pkg::*;
#(
  parameter int N_MST   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 256
) (
  input logic                     clk,
  input logic                     rst,
  axi_lite_rd_rr_arbiter_if.slave bus
);

  localparam int              PTR_W    = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_MST - 1);
  localparam bit              RR_EN    = (RR_MODE != 0);

  arb_state_t        state_q, state_d;
  logic [N_MST-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [N_MST-1:0]  pick;
  logic [ADDR_W-1:0] pick_addr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  ptr_adv;
  logic              rready_g;

  rr_pick #(.N(N_MST)) u_pick (
    .req_i     (bus.s_arvalid),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR_EN),
    .gnt_o     (pick)
  );

  always_comb begin
    pick_addr = '0;
    gidx      = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (pick[i])    pick_addr = bus.s_araddr[i*ADDR_W +: ADDR_W];
      if (grant_q[i]) gidx      = PTR_W'(i);
    end
  end

  // Fixed-priority mode never moves the pointer, so the picker always starts at index 0.
  assign ptr_adv  = !RR_EN ? ptr_q : ((gidx == PTR_LAST) ? '0 : gidx + PTR_W'(1));
  assign rready_g = |(bus.s_rready & grant_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (|bus.s_arvalid) begin
          state_d = ADDR;
          grant_d = pick;
          addr_d  = pick_addr;
        end
      end
      ADDR: begin
        if (bus.m_arready) begin
          state_d = DATA;
          wdog_d  = '0;
        end
      end
      DATA: begin
        // A beat arriving on the limit cycle wins over the timeout.
        if (bus.m_rvalid) begin
          if (rready_g) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = ptr_adv;
          end
        end else if ((TIMEOUT != 0) && (wdog_q == WD_LIMIT)) begin
          state_d = ERR;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ERR: begin
        if (rready_g) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.m_rvalid) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_adv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = RESP_OKAY;
    bus.m_araddr  = '0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.grant     = grant_q;
    case (state_q)
      ADDR: begin
        bus.m_arvalid = 1'b1;
        bus.m_araddr  = addr_q;
        bus.s_arready = grant_q & {N_MST{bus.m_arready}};
      end
      DATA: begin
        bus.s_rvalid = grant_q & {N_MST{bus.m_rvalid}};
        bus.s_rdata  = bus.m_rdata;
        bus.s_rresp  = bus.m_rresp;
        bus.m_rready = rready_g;
      end
      ERR: begin
        bus.s_rvalid = grant_q;
        bus.s_rresp  = RESP_SLVERR;
      end
      DRAIN: begin
        bus.m_rready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rd_rr_arbiter.sv
// Bench for axi_lite_rd_rr_arbiter: round-robin and fixed-priority instances share one stimulus stream;
// directed scenarios first, then randomized traffic against a transaction-level reference model.
module tb_axi_lite_rd_rr_arbiter;
  import ysyx_23060059_axi_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] s_araddr;
  logic [NM-1:0]    s_arvalid;
  logic [NM-1:0]    s_rready;
  logic             m_arready;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rvalid;

  int n_cmp = 0;
  int n_bad = 0;
  int mptr  = 0;

  logic [NM-1:0] pend, outst;
  logic [AW-1:0] paddr [NM];
  logic          mbusy, mem_act;
  int            mwin, mem_dly, er;

  axi_lite_rd_rr_arbiter_if #(.N_MST(NM), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
  axi_lite_rd_rr_arbiter_if #(.N_MST(NM), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

  assign bus_rr.s_araddr  = s_araddr;
  assign bus_rr.s_arvalid = s_arvalid;
  assign bus_rr.s_rready  = s_rready;
  assign bus_rr.m_arready = m_arready;
  assign bus_rr.m_rdata   = m_rdata;
  assign bus_rr.m_rresp   = m_rresp;
  assign bus_rr.m_rvalid  = m_rvalid;
  assign bus_fp.s_araddr  = s_araddr;
  assign bus_fp.s_arvalid = s_arvalid;
  assign bus_fp.s_rready  = s_rready;
  assign bus_fp.m_arready = m_arready;
  assign bus_fp.m_rdata   = m_rdata;
  assign bus_fp.m_rresp   = m_rresp;
  assign bus_fp.m_rvalid  = m_rvalid;

  axi_lite_rd_rr_arbiter #(
    .N_MST(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  axi_lite_rd_rr_arbiter #(
    .N_MST(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)
  ) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: scan requesters starting at ptr (round-robin) or at 0 (fixed).
  function automatic int pick_ref(input logic [NM-1:0] req, input int ptr, input bit rr);
    for (int k = 0; k < NM; k++) begin
      int i;
      i = rr ? (ptr + k) % NM : k;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return s_araddr[i*AW +: AW];
  endfunction

  // One complete read with both instances in lockstep; caller leaves s_arvalid set in an IDLE cycle.
  task automatic xact(input logic [DW-1:0] data);
    int e_rr, e_fp;
    e_rr = pick_ref(s_arvalid, mptr, 1'b1);
    e_fp = pick_ref(s_arvalid, 0, 1'b0);
    tick();
    m_arready = 1'b1;
    #1;
    chk("ar_grant_rr", 64'(bus_rr.grant), 64'(1) << e_rr);
    chk("ar_grant_fp", 64'(bus_fp.grant), 64'(1) << e_fp);
    chk("ar_mvalid_rr", 64'(bus_rr.m_arvalid), 64'(1));
    chk("ar_araddr_rr", 64'(bus_rr.m_araddr), 64'(addr_of(e_rr)));
    chk("ar_sready_rr", 64'(bus_rr.s_arready), 64'(1) << e_rr);
    tick();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    m_rresp   = 2'b00;
    s_rready  = 2'b11;
    #1;
    chk("r_valid_rr", 64'(bus_rr.s_rvalid), 64'(1) << e_rr);
    chk("r_valid_fp", 64'(bus_fp.s_rvalid), 64'(1) << e_fp);
    chk("r_data_rr", 64'(bus_rr.s_rdata), 64'(data));
    chk("r_resp_rr", 64'(bus_rr.s_rresp), 64'(0));
    chk("r_mready_rr", 64'(bus_rr.m_rready), 64'(1));
    tick();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    mptr     = (e_rr + 1) % NM;
    #1;
    chk("idle_grant_rr", 64'(bus_rr.grant), 64'(0));
  endtask

  initial begin
    rst       = 1'b0;
    s_araddr  = '0;
    s_arvalid = 2'b11;
    s_rready  = 2'b11;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hFFFF_FFFF;
    m_rresp   = 2'b11;
    repeat (3) tick();
    chk("rst_grant", 64'(bus_rr.grant), 64'(0));
    chk("rst_arready", 64'(bus_rr.s_arready), 64'(0));
    chk("rst_rvalid", 64'(bus_rr.s_rvalid), 64'(0));
    chk("rst_marvalid", 64'(bus_rr.m_arvalid), 64'(0));
    chk("rst_mrready", 64'(bus_rr.m_rready), 64'(0));
    chk("rst_rdata", 64'(bus_rr.s_rdata), 64'(0));
    chk("rst_rresp", 64'(bus_rr.s_rresp), 64'(0));
    chk("rst_grant_fp", 64'(bus_fp.grant), 64'(0));
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    tick();
    rst = 1'b1;
    tick();

    // Single master M1 request.
    s_araddr  = {32'h8000_0010, 32'h1111_0000};
    s_arvalid = 2'b10;
    #1;
    chk("t1_idle_arready", 64'(bus_rr.s_arready), 64'(0));
    chk("t1_idle_marvalid", 64'(bus_rr.m_arvalid), 64'(0));
    xact(32'hDEAD_BEEF);

    // Both masters requesting continuously, then M0 drops out.
    s_araddr  = {32'h0000_2004, 32'h0000_1000};
    s_arvalid = 2'b11;
    for (int k = 0; k < 6; k++) xact(32'h1000_0000 + 32'(k));
    s_arvalid = 2'b10;
    xact(32'h2000_0000);

    // Watchdog expiry, drain of the late beat, then a normal transaction.
    s_arvalid = 2'b01;
    er = pick_ref(s_arvalid, mptr, 1'b1);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_arvalid = 2'b00;
    for (int k = 0; k < TO; k++) begin
      #1;
      chk("t4_quiet_rvalid", 64'(bus_rr.s_rvalid), 64'(0));
      tick();
    end
    chk("t4_err_rvalid", 64'(bus_rr.s_rvalid), 64'(1) << er);
    chk("t4_err_rresp", 64'(bus_rr.s_rresp), 64'(2'b10));
    chk("t4_err_rdata", 64'(bus_rr.s_rdata), 64'(0));
    chk("t4_err_mrready", 64'(bus_rr.m_rready), 64'(0));
    chk("t4_err_rvalid_fp", 64'(bus_fp.s_rvalid), 64'(2'b01));
    s_rready = 2'b01;
    tick();
    s_rready = 2'b00;
    m_rvalid = 1'b1;
    m_rdata  = 32'hBAD0_BAD0;
    #1;
    chk("t4_drain_rvalid", 64'(bus_rr.s_rvalid), 64'(0));
    chk("t4_drain_mrready", 64'(bus_rr.m_rready), 64'(1));
    chk("t4_drain_rdata", 64'(bus_rr.s_rdata), 64'(0));
    tick();
    m_rvalid = 1'b0;
    mptr     = (er + 1) % NM;
    #1;
    chk("t4_back_idle", 64'(bus_rr.grant), 64'(0));
    s_arvalid = 2'b10;
    xact(32'h0BAD_F00D);

    // Beat arrives exactly on the last watchdog cycle.
    s_arvalid = 2'b01;
    er = pick_ref(s_arvalid, mptr, 1'b1);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_arvalid = 2'b00;
    repeat (TO - 1) tick();
    m_rvalid = 1'b1;
    m_rdata  = 32'h5555_AAAA;
    m_rresp  = 2'b00;
    s_rready = 2'b11;
    #1;
    chk("t5_rvalid", 64'(bus_rr.s_rvalid), 64'(1) << er);
    chk("t5_rresp", 64'(bus_rr.s_rresp), 64'(0));
    chk("t5_rdata", 64'(bus_rr.s_rdata), 64'(32'h5555_AAAA));
    tick();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    mptr     = (er + 1) % NM;
    #1;
    chk("t5_idle_rr", 64'(bus_rr.grant), 64'(0));
    chk("t5_idle_fp", 64'(bus_fp.grant), 64'(0));

    // Asynchronous reset with a beat pending in DATA.
    s_arvalid = 2'b01;
    er = pick_ref(s_arvalid, mptr, 1'b1);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_arvalid = 2'b00;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hCAFE_F00D;
    #1;
    chk("t6_pending", 64'(bus_rr.s_rvalid), 64'(1) << er);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rvalid", 64'(bus_rr.s_rvalid), 64'(0));
    chk("t6_grant", 64'(bus_rr.grant), 64'(0));
    chk("t6_mrready", 64'(bus_rr.m_rready), 64'(0));
    chk("t6_marvalid", 64'(bus_rr.m_arvalid), 64'(0));
    chk("t6_rdata", 64'(bus_rr.s_rdata), 64'(0));
    chk("t6_grant_fp", 64'(bus_fp.grant), 64'(0));
    tick();
    rst       = 1'b1;
    m_rvalid  = 1'b0;
    mptr      = 0;
    s_arvalid = 2'b11;
    xact(32'h600D_0001);

    // Randomized traffic on the round-robin instance.
    s_arvalid = '0;
    pend      = '0;
    outst     = '0;
    mbusy     = 1'b0;
    mem_act   = 1'b0;
    mem_dly   = 0;
    mwin      = 0;
    for (int i = 0; i < NM; i++) paddr[i] = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && !outst[i] && ($urandom_range(2) == 0)) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom() & 32'hFFFF_FFFC;
        end
      end
      s_arvalid = pend;
      for (int i = 0; i < NM; i++) s_araddr[i*AW +: AW] = paddr[i];
      s_rready  = NM'($urandom());
      m_arready = 1'($urandom());
      m_rvalid  = mem_act && (mem_dly == 0);
      m_rdata   = mem_act ? memf(paddr[mwin]) : 32'h0;
      m_rresp   = RESP_OKAY;
      #1;
      if (!mbusy) begin
        chk("rnd_idle_grant", 64'(bus_rr.grant), 64'(0));
        if (|s_arvalid) begin
          mwin  = pick_ref(s_arvalid, mptr, 1'b1);
          mbusy = 1'b1;
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (s_arvalid[i] && bus_rr.s_arready[i]) begin
          chk("rnd_ar_owner", 64'(i), 64'(mwin));
          chk("rnd_araddr", 64'(bus_rr.m_araddr), 64'(paddr[i]));
          pend[i]  = 1'b0;
          outst[i] = 1'b1;
        end
      end
      if (bus_rr.m_arvalid && m_arready) begin
        mem_act = 1'b1;
        mem_dly = int'($urandom_range(3));
      end
      if (m_rvalid) begin
        chk("rnd_rvalid", 64'(bus_rr.s_rvalid), 64'(1) << mwin);
        chk("rnd_mrready", 64'(bus_rr.m_rready), 64'(s_rready[mwin]));
        if (s_rready[mwin]) begin
          chk("rnd_rdata", 64'(bus_rr.s_rdata), 64'(memf(paddr[mwin])));
          chk("rnd_rresp", 64'(bus_rr.s_rresp), 64'(0));
          mem_act     = 1'b0;
          outst[mwin] = 1'b0;
          mbusy       = 1'b0;
          mptr        = (mwin + 1) % NM;
        end
      end
      tick();
      if (mem_act && (mem_dly > 0)) mem_dly--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
